// File: rtl/logic_func_identifier.sv
// Identifies which 4-bit logic-unit select code produced a stream of (a, b, f) samples.
// Optional early termination on <=1 candidate is enabled by defining LOGIC_ID_EARLY_EXIT_EN.
module logic_func_identifier #(
    parameter int MAX_SAMPLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic [3:0]  in_f,
    output logic        done,
    output logic        found,
    output logic [3:0]  func_code,
    output logic [15:0] cand_mask,
    output logic [7:0]  sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_SAMPLES);

    function automatic logic [3:0] f_eval(input logic [3:0] code, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [3:0] res;
        case (code)
            4'd0:    res = ~a;
            4'd1:    res = ~(a | b);
            4'd2:    res = ~a & b;
            4'd3:    res = 4'b0000;
            4'd4:    res = ~(a & b);
            4'd5:    res = ~b;
            4'd6:    res = a ^ b;
            4'd7:    res = a & ~b;
            4'd8:    res = ~a | b;
            4'd9:    res = ~(a ^ b);
            4'd10:   res = b;
            4'd11:   res = a & b;
            4'd12:   res = 4'b1111;
            4'd13:   res = a | ~b;
            4'd14:   res = a | b;
            default: res = a;
        endcase
        return res;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic        r_done;
    logic        r_found;
    logic [3:0]  r_func_code;
    logic [15:0] r_cand_mask;
    logic [7:0]  r_sample_cnt;

    logic [15:0] w_match;
    logic [15:0] w_mask_next;
    logic [7:0]  w_cnt_next;
    logic [4:0]  w_pop;
    logic [3:0]  w_low;
    logic        w_accept;
    logic        w_early;
    logic        w_term;

    // One comparator per candidate select code
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign w_match[gi] = (f_eval(4'(gi), in_a, in_b) == in_f);
        end
    endgenerate

    assign w_accept    = in_valid & in_ready;
    assign w_mask_next = r_cand_mask & w_match;
    assign w_cnt_next  = r_sample_cnt + 8'd1;

    always_comb begin
        w_pop = '0;
        w_low = '0;
        for (int k = 0; k < 16; k++) begin
            w_pop = w_pop + 5'(w_mask_next[k]);
        end
        for (int k = 15; k >= 0; k--) begin
            if (w_mask_next[k]) w_low = 4'(k);
        end
    end

`ifdef LOGIC_ID_EARLY_EXIT_EN
    assign w_early = (w_pop <= 5'd1);
`else
    assign w_early = 1'b0;
`endif

    assign w_term = (w_cnt_next == MAX_CNT) | w_early;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_COLLECT;
        end else if (r_state == S_COLLECT && w_accept && w_term) begin
            w_state_next = S_DONE;
        end
    end

    always_comb begin
        in_ready = (r_state == S_COLLECT) & ~start;
    end

    // Result registers load on the same edge that accepts the terminating sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_func_code  <= '0;
            r_cand_mask  <= 16'hFFFF;
            r_sample_cnt <= '0;
        end else if (start) begin
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_func_code  <= '0;
            r_cand_mask  <= 16'hFFFF;
            r_sample_cnt <= '0;
        end else if (w_accept) begin
            r_cand_mask  <= w_mask_next;
            r_sample_cnt <= w_cnt_next;
            if (w_term) begin
                r_done      <= 1'b1;
                r_found     <= (w_pop == 5'd1);
                r_func_code <= w_low;
            end
        end
    end

    assign done       = r_done;
    assign found      = r_found;
    assign func_code  = r_func_code;
    assign cand_mask  = r_cand_mask;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_logic_func_identifier.sv
// Directed testbench for logic_func_identifier; expectations follow LOGIC_ID_EARLY_EXIT_EN when defined.
module tb_logic_func_identifier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_a = '0;
    logic [3:0]  in_b = '0;
    logic [3:0]  in_f = '0;
    logic        done;
    logic        found;
    logic [3:0]  func_code;
    logic [15:0] cand_mask;
    logic [7:0]  sample_cnt;

    int checks = 0;
    int errors = 0;

    logic_func_identifier #(.MAX_SAMPLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_f(in_f), .done(done), .found(found),
        .func_code(func_code), .cand_mask(cand_mask), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_f = f;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found got=%b exp=0", found); end
        checks++; if (func_code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", func_code); end
        checks++; if (cand_mask !== 16'hFFFF) begin errors++; $display("FAIL reset_mask got=%h exp=ffff", cand_mask); end
        checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", sample_cnt); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_unique();
        logic [3:0] a, b;
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL uniq_ready got=%b exp=1", in_ready); end
        drive(4'b0011, 4'b0101, 4'b0110);
        checks++; if (cand_mask !== 16'h0040) begin errors++; $display("FAIL uniq_mask got=%h exp=0040", cand_mask); end
        checks++; if (sample_cnt !== 8'd1) begin errors++; $display("FAIL uniq_cnt got=%0d exp=1", sample_cnt); end
`ifdef LOGIC_ID_EARLY_EXIT_EN
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL uniq_done got=%b exp=1", done); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL uniq_found got=%b exp=1", found); end
        checks++; if (func_code !== 4'd6) begin errors++; $display("FAIL uniq_code got=%0d exp=6", func_code); end
`else
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL uniq_done_early got=%b exp=0", done); end
        for (int i = 1; i < 8; i++) begin
            a = 4'(i);
            b = 4'(i * 5);
            drive(a, b, a ^ b);
            checks++;
            if (done !== (i == 7)) begin errors++; $display("FAIL uniq_done_s%0d got=%b exp=%b", i + 1, done, (i == 7)); end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL uniq_found got=%b exp=1", found); end
        checks++; if (func_code !== 4'd6) begin errors++; $display("FAIL uniq_code got=%0d exp=6", func_code); end
        checks++; if (cand_mask !== 16'h0040) begin errors++; $display("FAIL uniq_mask8 got=%h exp=0040", cand_mask); end
        checks++; if (sample_cnt !== 8'd8) begin errors++; $display("FAIL uniq_cnt8 got=%0d exp=8", sample_cnt); end
`endif
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL uniq_ready_done got=%b exp=0", in_ready); end
        $display("test_unique done");
    endtask

    task automatic test_code15();
        pulse_start();
        drive(4'b0011, 4'b0101, 4'b0011);
        in_valid = 1'b0;
        checks++; if (cand_mask !== 16'h8000) begin errors++; $display("FAIL c15_mask got=%h exp=8000", cand_mask); end
`ifdef LOGIC_ID_EARLY_EXIT_EN
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL c15_found got=%b exp=1", found); end
        checks++; if (func_code !== 4'd15) begin errors++; $display("FAIL c15_code got=%0d exp=15", func_code); end
`else
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL c15_done got=%b exp=0", done); end
`endif
        $display("test_code15 done");
    endtask

    task automatic test_max_samples();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0000, 4'b0000, 4'b1111);
            checks++;
            if (done !== (i == 7)) begin errors++; $display("FAIL max_done_s%0d got=%b exp=%b", i + 1, done, (i == 7)); end
        end
        in_valid = 1'b0;
        checks++; if (cand_mask !== 16'h3333) begin errors++; $display("FAIL max_mask got=%h exp=3333", cand_mask); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL max_found got=%b exp=0", found); end
        checks++; if (func_code !== 4'd0) begin errors++; $display("FAIL max_code got=%0d exp=0", func_code); end
        checks++; if (sample_cnt !== 8'd8) begin errors++; $display("FAIL max_cnt got=%0d exp=8", sample_cnt); end
        $display("test_max_samples done");
    endtask

    task automatic test_ignore_in_done();
        in_valid = 1'b1;
        in_a = 4'b0011; in_b = 4'b0101; in_f = 4'b0110;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_ready got=%b exp=0", in_ready); end
        checks++; if (sample_cnt !== 8'd8) begin errors++; $display("FAIL done_cnt got=%0d exp=8", sample_cnt); end
        checks++; if (cand_mask !== 16'h3333) begin errors++; $display("FAIL done_mask got=%h exp=3333", cand_mask); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got=%b exp=1", done); end
        in_valid = 1'b0;
        $display("test_ignore_in_done done");
    endtask

    task automatic test_inconsistent();
        pulse_start();
        drive(4'b0000, 4'b0000, 4'b0000);
        checks++; if (cand_mask !== 16'hCCCC) begin errors++; $display("FAIL inc_mask1 got=%h exp=cccc", cand_mask); end
        drive(4'b0000, 4'b0000, 4'b1111);
        checks++; if (cand_mask !== 16'h0000) begin errors++; $display("FAIL inc_mask2 got=%h exp=0000", cand_mask); end
        checks++; if (sample_cnt !== 8'd2) begin errors++; $display("FAIL inc_cnt2 got=%0d exp=2", sample_cnt); end
`ifdef LOGIC_ID_EARLY_EXIT_EN
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL inc_done got=%b exp=1", done); end
`else
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL inc_done_early got=%b exp=0", done); end
        for (int i = 0; i < 6; i++) drive(4'b0000, 4'b0000, 4'b0000);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL inc_done got=%b exp=1", done); end
        checks++; if (sample_cnt !== 8'd8) begin errors++; $display("FAIL inc_cnt8 got=%0d exp=8", sample_cnt); end
`endif
        in_valid = 1'b0;
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL inc_found got=%b exp=0", found); end
        checks++; if (func_code !== 4'd0) begin errors++; $display("FAIL inc_code got=%0d exp=0", func_code); end
        $display("test_inconsistent done");
    endtask

    task automatic test_restart();
        pulse_start();
        drive(4'b0000, 4'b0000, 4'b1111);
        checks++; if (cand_mask !== 16'h3333) begin errors++; $display("FAIL rs_mask1 got=%h exp=3333", cand_mask); end
        start = 1'b1;
        in_valid = 1'b1;
        in_a = 4'b0011; in_b = 4'b0101; in_f = 4'b0110;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_ready_start got=%b exp=0", in_ready); end
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (cand_mask !== 16'hFFFF) begin errors++; $display("FAIL rs_mask got=%h exp=ffff", cand_mask); end
        checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL rs_cnt got=%0d exp=0", sample_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rs_ready got=%b exp=1", in_ready); end
        $display("test_restart done");
    endtask

    task automatic test_async_reset();
        drive(4'b0000, 4'b0000, 4'b1111);
        drive(4'b0000, 4'b0000, 4'b1111);
        in_valid = 1'b0;
        checks++; if (sample_cnt !== 8'd2) begin errors++; $display("FAIL ar_cnt_pre got=%0d exp=2", sample_cnt); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (cand_mask !== 16'hFFFF) begin errors++; $display("FAIL ar_mask got=%h exp=ffff", cand_mask); end
        checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", sample_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        $display("test_async_reset done");
    endtask

    task automatic test_ignore_in_idle();
        in_valid = 1'b1;
        in_a = 4'b0000; in_b = 4'b0000; in_f = 4'b1111;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", in_ready); end
        checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL idle_cnt got=%0d exp=0", sample_cnt); end
        checks++; if (cand_mask !== 16'hFFFF) begin errors++; $display("FAIL idle_mask got=%h exp=ffff", cand_mask); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done got=%b exp=0", done); end
        in_valid = 1'b0;
        $display("test_ignore_in_idle done");
    endtask

    initial begin
        test_reset();
        test_unique();
        test_code15();
        test_max_samples();
        test_ignore_in_done();
        test_inconsistent();
        test_restart();
        test_async_reset();
        test_ignore_in_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_func_identifier.md
# logic_func_identifier

Sequential inverse of the 16-function 4-bit logic unit: given a stream of observed (a, b, f) samples, it determines which 4-bit select code produced them. Each sample arrives over a valid/ready handshake and narrows a 16-bit candidate mask. The block reports the identified code, or an ambiguous or inconsistent result. It sits beside the ALU as a self-check and characterisation engine for the datapath test harness.

## Interface
Parameters:
- MAX_SAMPLES, 8, maximum samples accepted per identification run; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a new run from any state.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- in_a  in  4  observed A operand.
- in_b  in  4  observed B operand.
- in_f  in  4  observed F result.
- done  out  1  run complete; result outputs valid.
- found  out  1  exactly one candidate remains.
- func_code  out  4  identified select code.
- cand_mask  out  16  bit k set = select code k still consistent.
- sample_cnt  out  8  samples accepted in the current run.

## Operation
- Function table, bitwise on 4-bit vectors:
  - 0: ~a; 1: ~(a|b); 2: ~a&b; 3: 0000.
  - 4: ~(a&b); 5: ~b; 6: a^b; 7: a&~b.
  - 8: ~a|b; 9: ~(a^b); 10: b; 11: a&b.
  - 12: 1111; 13: a|~b; 14: a|b; 15: a.
- Match vector: bit k = (table_k(in_a, in_b) == in_f), computed combinationally.
- States: IDLE, COLLECT, DONE.
- IDLE: in_ready=0. start → COLLECT, with cand_mask=16'hFFFF, sample_cnt=0, done=0.
- COLLECT:
  - in_ready = ~start.
  - On each accepted sample: cand_mask <= cand_mask & match and sample_cnt <= sample_cnt+1.
  - Terminate to DONE when the updated sample_cnt == MAX_SAMPLES, or when early exit is compiled in and popcount(updated mask) ≤ 1.
- DONE:
  - done=1 and in_ready=0.
  - found = (popcount(cand_mask)==1).
  - func_code = index of the lowest set bit of cand_mask; 0 if the mask is zero.
  - DONE holds until start or rst.
- start in COLLECT or DONE: restart exactly as from IDLE. A sample presented in the same cycle as start is not accepted.
- in_valid while not in COLLECT: ignored, not consumed.
- rst: state=IDLE, in_ready=0, done=0, found=0, func_code=0, cand_mask=16'hFFFF, sample_cnt=0.

## Timing
- in_ready is combinational from state and start. All other outputs are registered.
- The cycle after start: state=COLLECT, in_ready=1 (if start is low).
- Sample-to-mask latency is 1 cycle: cand_mask and sample_cnt update on the edge that accepts the sample.
- done, found and func_code become valid 1 cycle after the terminating sample is accepted.
- Throughput is one sample per cycle. in_valid may stay high back-to-back.
- Asynchronous rst takes effect immediately, mid-run included. Operation resumes on the first edge after rst deasserts, in IDLE.

## Configuration
- LOGIC_ID_EARLY_EXIT_EN defined: the run terminates as soon as ≤1 candidate remains (unique or inconsistent), or at MAX_SAMPLES.
- LOGIC_ID_EARLY_EXIT_EN undefined: every run accepts exactly MAX_SAMPLES samples before DONE. The result rules are unchanged.

## Test plan
- Early exit on, start, then sample a=0011 b=0101 f=0110 → one cycle later: done=1, found=1, func_code=6, cand_mask=16'h0040, sample_cnt=1.
- Early exit on, sample a=0011 b=0101 f=0011 → found=1, func_code=15, cand_mask=16'h8000.
- MAX_SAMPLES=8, eight samples a=0000 b=0000 f=1111 → done after the 8th, cand_mask=16'h3333, found=0, func_code=0, sample_cnt=8.
- Early exit on, samples (0000,0000,0000) then (0000,0000,1111) → done after the 2nd, cand_mask=16'h0000, found=0, func_code=0.
- Restart and reset mid-run:
  - start pulsed mid-COLLECT with in_valid=1 → that sample is not accepted, cand_mask=16'hFFFF, sample_cnt=0.
  - rst asserted mid-COLLECT → outputs immediately return to reset values.
- in_valid held high in IDLE and in DONE → in_ready=0, sample_cnt unchanged. Early exit off: a unique sample followed by 7 more → done only after the 8th.
